// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: ROM synchronous read port, execute redirect and the decode handshake.
// master = fetch unit, slave = the ROM/execute/decode environment around it.
interface inst_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_read_data;
  logic                  branch_flag;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  id_ready;
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [DATA_WIDTH-1:0] if_inst;
  logic                  if_addr_err;

  modport master (
    output rom_en, rom_addr, if_valid, if_pc, if_inst, if_addr_err,
    input  rom_read_data, branch_flag, branch_target, id_ready
  );

  modport slave (
    input  rom_en, rom_addr, if_valid, if_pc, if_inst, if_addr_err,
    output rom_read_data, branch_flag, branch_target, id_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: drives the ROM read port, buffers returned words in a 2-entry queue
// and hands {pc, inst} to decode; execute redirects flush everything in flight.
`ifndef INIT_PC
`define INIT_PC 32'h0000_0000
`endif

module inst_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] INIT_PC    = `INIT_PC
) (
  input  logic           clk,
  input  logic           rst,
  inst_fetch_if.master   bus
);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [ADDR_WIDTH-1:0] err_pc;
  logic                  inflight;
  logic                  err_halt;
  logic                  err_pending;
  logic [1:0]            count;

  logic [ADDR_WIDTH-1:0] q_pc0, q_pc1;
  logic [DATA_WIDTH-1:0] q_inst0, q_inst1;
  logic                  q_err0, q_err1;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  misaligned;
  logic                  tail_slot;
  logic [2:0]            fill;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [ADDR_WIDTH-1:0] push_pc;
  logic [DATA_WIDTH-1:0] push_inst;
  logic                  push_err;

  assign bus.if_valid    = !rst && (count != 2'd0) && !bus.branch_flag;
  assign bus.if_pc       = rst ? '0 : q_pc0;
  assign bus.if_inst     = rst ? '0 : q_inst0;
  assign bus.if_addr_err = rst ? 1'b0 : q_err0;
  assign bus.rom_en      = issue;
  assign bus.rom_addr    = fetch_addr;

  always_comb begin
    pop        = bus.if_valid && bus.id_ready;
    fill       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    misaligned = bus.branch_target[1:0] != 2'b00;
    fetch_addr = pc;
    issue      = 1'b0;
    if (rst) begin
      fetch_addr = INIT_PC;
    end else if (bus.branch_flag) begin
      // the flush empties the queue, so the target can be fetched immediately
      fetch_addr = bus.branch_target;
      issue      = !misaligned;
    end else begin
      issue = !err_halt && (fill < 3'd2);
    end

    // a response returning during a redirect belongs to the old path and is dropped
    push      = !rst && !bus.branch_flag && (inflight || err_pending);
    push_pc   = err_pending ? err_pc : req_pc;
    push_inst = err_pending ? '0 : bus.rom_read_data;
    push_err  = err_pending;
    tail_slot = (count == 2'd2) || ((count == 2'd1) && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= INIT_PC;
      req_pc      <= '0;
      err_pc      <= '0;
      inflight    <= 1'b0;
      err_halt    <= 1'b0;
      err_pending <= 1'b0;
      count       <= 2'd0;
      q_pc0       <= '0;
      q_pc1       <= '0;
      q_inst0     <= '0;
      q_inst1     <= '0;
      q_err0      <= 1'b0;
      q_err1      <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc     <= fetch_addr + ADDR_WIDTH'(4);
        req_pc <= fetch_addr;
      end

      if (bus.branch_flag) begin
        count       <= 2'd0;
        err_halt    <= misaligned;
        err_pending <= misaligned;
        err_pc      <= bus.branch_target;
      end else begin
        err_pending <= 1'b0;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase

        if (pop) begin
          q_pc0   <= q_pc1;
          q_inst0 <= q_inst1;
          q_err0  <= q_err1;
        end
        // later assignment wins, so a push into slot 0 overrides the shift
        if (push) begin
          if (tail_slot) begin
            q_pc1   <= push_pc;
            q_inst1 <= push_inst;
            q_err1  <= push_err;
          end else begin
            q_pc0   <= push_pc;
            q_inst0 <= push_inst;
            q_err0  <= push_err;
          end
        end
      end
    end
  end

  queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == 2'd2)));

endmodule
